// File: rtl/sdhci_irq_pkg.sv
// Purpose: shared types and default source layout for the SDHCI interrupt engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sdhci_irq_pkg;

  // Coalescing state: IDLE waits for the first signalled event, PEND accumulates.
  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } coal_state_e;

  // Normal interrupt status layout (16 sources).
  localparam logic [15:0] NORM_CMD_CMPL    = 16'h0001;
  localparam logic [15:0] NORM_XFER_CMPL   = 16'h0002;
  localparam logic [15:0] NORM_BUF_WR_RDY  = 16'h0010;
  localparam logic [15:0] NORM_BUF_RD_RDY  = 16'h0020;
  localparam logic [15:0] NORM_CARD_INS    = 16'h0040;
  localparam logic [15:0] NORM_CARD_REM    = 16'h0080;
  localparam logic [15:0] NORM_DEF_MASK    = NORM_CMD_CMPL | NORM_XFER_CMPL | NORM_BUF_WR_RDY |
                                             NORM_BUF_RD_RDY | NORM_CARD_INS | NORM_CARD_REM;

  // Error interrupt status layout: command and data error bits.
  localparam logic [15:0] ERR_CMD_TMO      = 16'h0001;
  localparam logic [15:0] ERR_CMD_CRC      = 16'h0002;
  localparam logic [15:0] ERR_CMD_END      = 16'h0004;
  localparam logic [15:0] ERR_CMD_IDX      = 16'h0008;
  localparam logic [15:0] ERR_DAT_TMO      = 16'h0010;
  localparam logic [15:0] ERR_DAT_CRC      = 16'h0020;
  localparam logic [15:0] ERR_DAT_END      = 16'h0040;
  localparam logic [15:0] ERR_DEF_MASK     = 16'h007F;

endpackage

// File: rtl/sdhci_irq_coalesce.sv
// Purpose: interrupt coalescing FSM (IDLE/PEND) with saturating event count and timeout timer.
// Latency: irq_pulse_o is registered, one cycle after the triggering new_evt_i / timeout compare.
// Backpressure: none; one event is counted per cycle, extra simultaneous sources collapse into it.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   new_evt_i         at least one signal-enabled status bit is being set this cycle
//   irq_level_i       aggregated level IRQ (registered status & signal enable)
//   coal_thresh_i     events per pulse (0/1 = pulse per event)
//   coal_tmo_i        cycles in PEND before a forced pulse (0 = disabled)
//   irq_pulse_o       one-cycle coalesced pulse
//   pend_cnt_o        current pending event count
module sdhci_irq_coalesce
  import sdhci_irq_pkg::*;
#(
  parameter int CntWidth = 8,
  parameter int TmoWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                new_evt_i,
  input  logic                irq_level_i,
  input  logic [CntWidth-1:0] coal_thresh_i,
  input  logic [TmoWidth-1:0] coal_tmo_i,
  output logic                irq_pulse_o,
  output logic [CntWidth-1:0] pend_cnt_o
);

  coal_state_e         state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [TmoWidth-1:0] tmr_q, tmr_d;
  logic                pulse_q, pulse_d;

  // One extra bit so the compares never wrap at the top of the range.
  logic [CntWidth:0]   cnt_sum;
  logic [TmoWidth:0]   tmr_inc;
  logic                thr_hit;
  logic                tmo_hit;

  always_comb begin
    cnt_sum = {1'b0, cnt_q} + {{CntWidth{1'b0}}, new_evt_i};
    tmr_inc = {1'b0, tmr_q} + {{TmoWidth{1'b0}}, 1'b1};
    thr_hit = (cnt_sum >= {1'b0, coal_thresh_i});
    tmo_hit = (coal_tmo_i != '0) && (tmr_inc >= {1'b0, coal_tmo_i});

    state_d = state_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    pulse_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (new_evt_i) begin
          if (coal_thresh_i <= CntWidth'(1)) begin
            pulse_d = 1'b1;
          end else begin
            cnt_d   = CntWidth'(1);
            tmr_d   = '0;
            state_d = PEND;
          end
        end
      end
      PEND: begin
        // Count and timer both saturate rather than wrap.
        cnt_d = cnt_sum[CntWidth] ? cnt_q : cnt_sum[CntWidth-1:0];
        tmr_d = tmr_inc[TmoWidth] ? tmr_q : tmr_inc[TmoWidth-1:0];
        if (thr_hit || tmo_hit) begin
          // Threshold and timeout in the same cycle still yield one pulse.
          pulse_d = 1'b1;
          cnt_d   = '0;
          tmr_d   = '0;
          state_d = IDLE;
        end else if (!irq_level_i && !new_evt_i) begin
          // Software cleared everything: drop the batch silently. A fresh event in
          // the same cycle keeps the batch alive since its status lands next cycle.
          cnt_d   = '0;
          tmr_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tmr_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      pulse_q <= pulse_d;
    end
  end

  assign irq_pulse_o = pulse_q;
  assign pend_cnt_o  = cnt_q;

endmodule

// File: rtl/sdhci_irq_ctrl.sv
// Purpose: SDHCI interrupt status engine: per-source edge detect, sticky W1C status, gating,
//          summary bit, level IRQ and coalesced IRQ pulse.
// Latency: status 1 cycle after the source edge; level/summary combinational from status;
//          pulse 1 cycle after the coalescing decision.
// Backpressure: none; W1C clears apply unconditionally, a simultaneous set wins.
// Ports:
//   clk_i, rst_i    clock, synchronous active-high reset
//   src_i           raw hardware level per source
//   src_gate_i      per-source domain reset (forces status low, masks edges)
//   status_en_i     per-source latch enable
//   signal_en_i     per-source IRQ enable
//   clr_valid_i     W1C strobe, clr_i the W1C data
//   coal_thresh_i   coalescing threshold, coal_tmo_i coalescing timeout
//   status_o        sticky status, summary_o masked error summary
//   irq_level_o     level IRQ, irq_pulse_o coalesced pulse, pend_cnt_o pending count
module sdhci_irq_ctrl
  import sdhci_irq_pkg::*;
#(
  parameter int                NumSrc      = 16,
  parameter logic [NumSrc-1:0] EdgeRise    = '1,
  parameter logic [NumSrc-1:0] EdgeFall    = '0,
  parameter logic [NumSrc-1:0] SummaryMask = '0,
  parameter int                CntWidth    = 8,
  parameter int                TmoWidth    = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NumSrc-1:0]   src_i,
  input  logic [NumSrc-1:0]   src_gate_i,
  input  logic [NumSrc-1:0]   status_en_i,
  input  logic [NumSrc-1:0]   signal_en_i,
  input  logic                clr_valid_i,
  input  logic [NumSrc-1:0]   clr_i,
  input  logic [CntWidth-1:0] coal_thresh_i,
  input  logic [TmoWidth-1:0] coal_tmo_i,
  output logic [NumSrc-1:0]   status_o,
  output logic                summary_o,
  output logic                irq_level_o,
  output logic                irq_pulse_o,
  output logic [CntWidth-1:0] pend_cnt_o
);

  logic [NumSrc-1:0] prev_q;
  logic [NumSrc-1:0] status_q;
  logic [NumSrc-1:0] edge_det;
  logic [NumSrc-1:0] set_vec;
  logic              new_evt;

  // prev tracks the source even while gated, so releasing a gate with the
  // source already high produces no edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) prev_q <= '0;
    else       prev_q <= src_i;
  end

  for (genvar i = 0; i < NumSrc; i++) begin : g_src
    assign edge_det[i] = (EdgeRise[i] &  src_i[i] & ~prev_q[i]) |
                         (EdgeFall[i] & ~src_i[i] &  prev_q[i]);
    assign set_vec[i]  = edge_det[i] & status_en_i[i] & ~src_gate_i[i];

    // Priority: gate, then set, then W1C clear.
    always_ff @(posedge clk_i) begin
      if (rst_i)                         status_q[i] <= 1'b0;
      else if (src_gate_i[i])            status_q[i] <= 1'b0;
      else if (set_vec[i])               status_q[i] <= 1'b1;
      else if (clr_valid_i && clr_i[i])  status_q[i] <= 1'b0;
    end
  end

  assign status_o    = status_q;
  assign summary_o   = |(status_q & SummaryMask);
  assign irq_level_o = |(status_q & signal_en_i);
  assign new_evt     = |(set_vec & signal_en_i);

  sdhci_irq_coalesce #(
    .CntWidth (CntWidth),
    .TmoWidth (TmoWidth)
  ) u_coalesce (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .new_evt_i     (new_evt),
    .irq_level_i   (irq_level_o),
    .coal_thresh_i (coal_thresh_i),
    .coal_tmo_i    (coal_tmo_i),
    .irq_pulse_o   (irq_pulse_o),
    .pend_cnt_o    (pend_cnt_o)
  );

endmodule

// File: tb/tb_sdhci_irq_ctrl.sv
// Purpose: directed self-checking bench for sdhci_irq_ctrl (bit 3 falling-edge, summary on 7:4).
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled at the same point.
// Backpressure: n/a.
module tb_sdhci_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] src, src_gate, status_en, signal_en, clr;
  logic        clr_valid;
  logic [7:0]  coal_thresh;
  logic [15:0] coal_tmo;
  logic [15:0] status;
  logic        summary, irq_level, irq_pulse;
  logic [7:0]  pend_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sdhci_irq_ctrl #(
    .NumSrc      (16),
    .EdgeRise    (16'hFFF7),
    .EdgeFall    (16'h0008),
    .SummaryMask (16'h00F0),
    .CntWidth    (8),
    .TmoWidth    (16)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .src_i         (src),
    .src_gate_i    (src_gate),
    .status_en_i   (status_en),
    .signal_en_i   (signal_en),
    .clr_valid_i   (clr_valid),
    .clr_i         (clr),
    .coal_thresh_i (coal_thresh),
    .coal_tmo_i    (coal_tmo),
    .status_o      (status),
    .summary_o     (summary),
    .irq_level_o   (irq_level),
    .irq_pulse_o   (irq_pulse),
    .pend_cnt_o    (pend_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    src = '0;
    clr_valid = 1'b0;
    clr = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  int pulses;
  int pulse_at;
  logic [7:0] cnt_seen [0:15];

  initial begin
    src_gate    = '0;
    status_en   = 16'hFFFF;
    signal_en   = '0;
    coal_thresh = 8'd0;
    coal_tmo    = 16'd0;
    do_reset();

    chk("rst_status",  {16'h0, status}, 32'h0);
    chk("rst_summary", {31'h0, summary}, 32'h0);
    chk("rst_level",   {31'h0, irq_level}, 32'h0);
    chk("rst_pulse",   {31'h0, irq_pulse}, 32'h0);
    chk("rst_pend",    {24'h0, pend_cnt}, 32'h0);

    // Rising source 0: set after one cycle, W1C clears it.
    src[0] = 1'b1;
    chk("rise_before", {31'h0, status[0]}, 32'h0);
    tick();
    chk("rise_set", {31'h0, status[0]}, 32'h1);
    clr_valid = 1'b1; clr = 16'h0001;
    tick();
    clr_valid = 1'b0; clr = '0;
    chk("rise_clr", {16'h0, status}, 32'h0);

    // Falling-edge source 3.
    src[3] = 1'b1;
    tick();
    chk("fall_rise_nop", {31'h0, status[3]}, 32'h0);
    src[3] = 1'b0;
    tick();
    chk("fall_set", {31'h0, status[3]}, 32'h1);
    src[3] = 1'b1;
    tick();
    src[3] = 1'b0; clr_valid = 1'b1; clr = 16'h0008;
    tick();
    chk("set_beats_clr", {31'h0, status[3]}, 32'h1);
    tick();
    clr_valid = 1'b0; clr = '0;
    chk("clr_alone", {31'h0, status[3]}, 32'h0);

    // Status enable off: edge not latched.
    status_en[1] = 1'b0;
    src[1] = 1'b1;
    tick();
    chk("en_off", {31'h0, status[1]}, 32'h0);
    status_en[1] = 1'b1;

    // Gate on source 2.
    src_gate[2] = 1'b1; src[2] = 1'b1;
    tick();
    chk("gate_mask", {31'h0, status[2]}, 32'h0);
    tick();
    src_gate[2] = 1'b0;
    tick();
    chk("gate_release", {31'h0, status[2]}, 32'h0);
    src[2] = 1'b0;
    tick();
    src[2] = 1'b1;
    tick();
    chk("ungated_set", {31'h0, status[2]}, 32'h1);
    src_gate[2] = 1'b1;
    tick();
    chk("gate_clears", {31'h0, status[2]}, 32'h0);
    src_gate[2] = 1'b0;

    // Summary on bit 5 with signal enables off.
    src[5] = 1'b1;
    tick();
    chk("sum_status", {31'h0, status[5]}, 32'h1);
    chk("sum_set",    {31'h0, summary}, 32'h1);
    chk("sum_level",  {31'h0, irq_level}, 32'h0);
    chk("sum_nopulse", {31'h0, irq_pulse}, 32'h0);

    // Reset mid-operation.
    do_reset();
    chk("midrst_status", {16'h0, status}, 32'h0);
    chk("midrst_sum",    {31'h0, summary}, 32'h0);

    // Coalescing: thresh 3, events at cycles 0,5,9.
    signal_en = 16'hFFFF;
    coal_thresh = 8'd3; coal_tmo = 16'd0;
    pulses = 0; pulse_at = -1;
    for (int c = 0; c < 16; c++) begin
      cnt_seen[c] = pend_cnt;
      if (irq_pulse) begin pulses++; if (pulse_at < 0) pulse_at = c; end
      if (c == 0) src[0] = 1'b1;
      if (c == 5) src[1] = 1'b1;
      if (c == 9) src[4] = 1'b1;
      tick();
    end
    chk("coal_cnt1",   {24'h0, cnt_seen[1]}, 32'd1);
    chk("coal_cnt2",   {24'h0, cnt_seen[6]}, 32'd2);
    chk("coal_cnt0",   {24'h0, cnt_seen[10]}, 32'd0);
    chk("coal_at",     pulse_at, 32'd10);
    chk("coal_pulses", pulses, 32'd1);

    // Timeout: thresh 4, tmo 20, single event. Status is visible one cycle after
    // the edge; the forced pulse follows 20 cycles after that.
    do_reset();
    coal_thresh = 8'd4; coal_tmo = 16'd20;
    pulses = 0; pulse_at = -1;
    for (int c = 0; c < 30; c++) begin
      if (irq_pulse) begin pulses++; if (pulse_at < 0) pulse_at = c; end
      if (c == 0) src[0] = 1'b1;
      tick();
    end
    chk("tmo_at",     pulse_at, 32'd21);
    chk("tmo_pulses", pulses, 32'd1);

    // Timeout aborted by software clearing everything.
    do_reset();
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      cnt_seen[c % 16] = pend_cnt;
      if (c == 3) chk("abort_pend", {24'h0, pend_cnt}, 32'd1);
      if (irq_pulse) pulses++;
      clr_valid = 1'b0; clr = '0;
      if (c == 0) src[0] = 1'b1;
      if (c == 5) begin clr_valid = 1'b1; clr = 16'hFFFF; end
      tick();
    end
    chk("abort_cnt",    {24'h0, cnt_seen[8]}, 32'd0);
    chk("abort_nopulse", pulses, 32'd0);

    // Threshold 1: back-to-back events give back-to-back pulses.
    do_reset();
    coal_thresh = 8'd1; coal_tmo = 16'd0;
    src[0] = 1'b1;
    tick();
    src[1] = 1'b1;
    chk("t1_p0", {31'h0, irq_pulse}, 32'h1);
    tick();
    chk("t1_p1", {31'h0, irq_pulse}, 32'h1);
    tick();
    chk("t1_p2", {31'h0, irq_pulse}, 32'h0);
    chk("t1_pend", {24'h0, pend_cnt}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
